d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop.sv | 82 ++++++++
 tb/tb_d_flip_flop.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// ---------------------------------------------------------------------------
// d_flip_flop
//
// Purpose:
//    A positive-edge D flip-flop with an asynchronous active-high reset and
//    complementary outputs. It is the basic storage cell of the gate-level
//    modelling library. Each bit is built only from gate primitives, as a
//    master-slave pair of cross-coupled NAND latches.
//
//    The master latch is transparent while clk is low. The slave latch is
//    transparent while clk is high. So the value on D just before a rising
//    edge is passed to Q, and Q then holds until the next rising edge.
//
// Parameters:
//    WIDTH  Number of independent flip-flop bits. Each bit is one identical
//           master-slave cell, and there is no logic between bits.
//
// Ports:
//    clk  Clock. State is captured on the rising edge only.
//    rst  Asynchronous, active-high reset. Forces Q=0 and Qn=1 on every bit,
//         and also clears the master latch.
//    D    Data input, sampled at the rising edge of clk.
//    Q    Stored value.
//    Qn   Bitwise complement of Q.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module d_flip_flop #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn
);

   // Shared by every bit: the inverted clock enables the master latch,
   // and the inverted reset is the clear term for both latches.
   wire clk_n;
   wire rst_n;

   not u_clk_inv (clk_n, clk);
   not u_rst_inv (rst_n, rst);

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         wire d_n;
         wire m_set_n;
         wire m_clr_n;
         wire m_q;
         wire m_qn;
         wire s_set_n;
         wire s_clr_n;

         not u_d_inv (d_n, D[i]);

         // Master gated latch, open while clk is low.
         // Reset does two things here. It blocks the set steering term, so
         // a 1 on D cannot fight the clear. It also forces m_qn high, which
         // in turn drives m_q low. As a result, the master leaves reset
         // already holding 0, and the first rising edge after release can
         // only pass on data that was sampled with rst low.
         nand u_m_set (m_set_n, D[i], clk_n, rst_n);
         nand u_m_clr (m_clr_n, d_n, clk_n);
         nand u_m_q   (m_q, m_set_n, m_qn);
         nand u_m_qn  (m_qn, m_clr_n, m_q, rst_n);

         // Slave gated latch, open while clk is high. Its data comes from
         // the master's complementary outputs. Reset gates the slave the
         // same way as the master, so Q=0 and Qn=1 settle as soon as rst
         // rises, whatever the clock phase. Gating the set term as well
         // means Q and Qn are never both 1 or both 0 once settled.
         nand u_s_set (s_set_n, m_q, clk, rst_n);
         nand u_s_clr (s_clr_n, m_qn, clk);
         nand u_s_q   (Q[i], s_set_n, Qn[i]);
         nand u_s_qn  (Qn[i], s_clr_n, Q[i], rst_n);
      end
   endgenerate

endmodule

// File: tb/tb_d_flip_flop.sv
// ---------------------------------------------------------------------------
// tb_d_flip_flop
//
// Purpose:
//    Self-checking bench for a 4-bit d_flip_flop. It has two parts:
//    - Directed scenarios: reset, capture, async reset mid-cycle, hold
//      against D activity and the falling edge, the reference (D,rst)
//      sequence, and the multi-bit pattern.
//    - A randomized run, checked against a behavioural reference model.
//
// Timing:
//    The clock period is 10ns, with rising edges at 5, 15, 25, and so on.
//    Inputs change on the falling edge or during the high phase. Outputs are
//    sampled a few ns away from every edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_d_flip_flop;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] D;
   logic [W-1:0] Q;
   logic [W-1:0] Qn;

   logic [W-1:0] modelQ;
   int           checkCount;
   int           errorCount;

   d_flip_flop #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .D   (D),
      .Q   (Q),
      .Qn  (Qn)
   );

   // Free-running clock, starting low.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of the cell's rules.
   // A high rst empties the cell straight away.
   // Otherwise, a rising clk edge stores what D currently shows.
   // Nothing else changes the stored value.
   always @(posedge clk or posedge rst) begin
      if (rst)
         modelQ <= '0;
      else
         modelQ <= D;
   end

   // Counts one comparison, and prints a line when it does not match.
   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %b expected %b at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Checks both outputs against a single expected stored value.
   task automatic checkState(input string tag, input logic [W-1:0] expQ);
      checkOutput({tag, "_q"}, Q, expQ);
      checkOutput({tag, "_qn"}, Qn, ~expQ);
   endtask

   task automatic applyStimulus(input logic [W-1:0] d, input logic r);
      D   = d;
      rst = r;
   endtask

   // Advances to an absolute simulation time, given in ns.
   task automatic waitTo(input int t);
      #(t - $time);
   endtask

   initial begin
      logic [W-1:0] seqD [7];
      logic         seqR [7];
      logic [W-1:0] seqQ [7];
      logic [W-1:0] rd;
      logic         rr;
      int           base;

      checkCount = 0;
      errorCount = 0;

      // Reset holds while clk toggles and D moves.
      applyStimulus(4'h0, 1'b1);
      waitTo(2);   checkState("reset_d0", 4'h0);
      waitTo(10);  applyStimulus(4'hF, 1'b1);
      waitTo(17);  checkState("reset_d1_edge", 4'h0);

      // Capture, hold without an edge, then capture 0.
      waitTo(20);  applyStimulus(4'hF, 1'b0);
      waitTo(27);  checkState("capture_1", 4'hF);
      waitTo(30);  D = 4'h0;
      waitTo(32);  checkState("no_edge_hold", 4'hF);
      waitTo(37);  checkState("capture_0", 4'h0);

      // Async reset pulse while clk is high.
      waitTo(40);  D = 4'hF;
      waitTo(44);  checkState("pre_pulse", 4'h0);
      waitTo(46);  rst = 1'b1;
      waitTo(47);  checkState("async_clear", 4'h0);
      waitTo(49);  rst = 1'b0;
      waitTo(52);  checkState("after_pulse", 4'h0);
      waitTo(57);  checkState("recapture", 4'hF);

      // Hold against D activity while high and on the falling edge.
      waitTo(60);  D = 4'hF;
      waitTo(66);  D = 4'h0;
      waitTo(67);  D = 4'h5;
      waitTo(68);  D = 4'h0;
      waitTo(69);  checkState("hold_high", 4'hF);
      waitTo(70);  D = 4'hA;
      waitTo(72);  D = 4'h0;
      waitTo(73);  checkState("hold_fall", 4'hF);
      waitTo(77);  checkState("next_edge", 4'h0);

      // Reference (D,rst) sequence, one rising edge per 10ns step.
      seqD = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF};
      seqR = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      seqQ = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
      for (int s = 0; s < 7; s++) begin
         waitTo(80 + 10 * s);
         applyStimulus(seqD[s], seqR[s]);
         waitTo(87 + 10 * s);
         checkState($sformatf("seq%0d", s), seqQ[s]);
      end

      // Multi-bit pattern.
      waitTo(150); applyStimulus(4'h0, 1'b1);
      waitTo(152); checkState("w4_reset", 4'h0);
      waitTo(160); applyStimulus(4'b1010, 1'b0);
      waitTo(167); checkState("w4_capture", 4'b1010);
      waitTo(170); rst = 1'b1;
      waitTo(172); checkState("w4_clear", 4'b0000);
      waitTo(180); rst = 1'b0;

      // Randomized run against the model.
      for (int n = 0; n < 150; n++) begin
         base = 190 + 10 * n;
         waitTo(base);
         rd = W'($urandom);
         rr = ($urandom_range(0, 7) == 0);
         applyStimulus(rd, rr);
         waitTo(base + 2);
         checkState("rnd_low", modelQ);
         waitTo(base + 7);
         checkState("rnd_edge", modelQ);
         D = W'($urandom);
         if ($urandom_range(0, 5) == 0)
            rst = 1'b1;
         waitTo(base + 8);
         rst = 1'b0;
         waitTo(base + 9);
         checkState("rnd_high", modelQ);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
